// File: rtl/mul_float_pkg.sv
// Shared constants, tag-FIFO entry type and id-width helper for the
// float multiplier arbiter.
package mul_float_pkg;

    localparam logic [31:0] P_ZERO = 32'h0000_0000;
    localparam logic [31:0] P_INF  = 32'h7F80_0000;
    localparam logic [31:0] P_NAN  = 32'h7FC0_0000;

    // Widest requester id supported (8 requesters).
    localparam int P_TAG_ID_W = 3;

    typedef struct packed {
        logic [P_TAG_ID_W-1:0] id;
    } tag_entry_t;

    function automatic int f_id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mul_float_tag_fifo.sv
// In-order tag FIFO: remembers which requester owns each multiplier op.
module mul_float_tag_fifo
    import mul_float_pkg::*;
#(
    parameter int P_DEPTH = 8,
    localparam int CW = $clog2(P_DEPTH + 1),
    localparam int PW = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1
) (
    input  logic          iCLOCK,
    input  logic          inRESET,
    input  logic          iCLEAR,
    input  logic          iPUSH,
    input  tag_entry_t    iPUSH_DATA,
    input  logic          iPOP,
    output tag_entry_t    oHEAD,
    output logic [CW-1:0] oCOUNT,
    output logic          oEMPTY
);

    tag_entry_t    mem_q [P_DEPTH];
    tag_entry_t    mem_d [P_DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic          full, empty, do_push, do_pop;

    always_comb begin
        full    = (count_q == CW'(P_DEPTH));
        empty   = (count_q == '0);
        do_push = iPUSH && !full;
        do_pop  = iPOP && !empty;

        mem_d = mem_q;
        if (do_push) mem_d[wr_q] = iPUSH_DATA;

        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = (wr_q == PW'(P_DEPTH - 1)) ? '0 : wr_q + 1'b1;
        if (do_pop)  rd_d = (rd_q == PW'(P_DEPTH - 1)) ? '0 : rd_q + 1'b1;

        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Clearing drops in-flight tags; stale memory contents are harmless.
        if (iCLEAR) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            mem_q   <= '{default: '0};
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    assign oHEAD  = mem_q[rd_q];
    assign oCOUNT = count_q;
    assign oEMPTY = empty;

endmodule

// File: rtl/mul_float_arbiter.sv
// Round-robin sharing of one pipelined float multiplier among P_REQ_N
// requesters, with registered issue and response stages.
module mul_float_arbiter
    import mul_float_pkg::*;
#(
    parameter int P_REQ_N     = 4,
    parameter int P_TAG_DEPTH = 8,
    parameter int P_ID_W      = f_id_w(P_REQ_N)
) (
    input  logic                  iCLOCK,
    input  logic                  inRESET,
    input  logic                  iRESET_SYNC,
    input  logic [P_REQ_N-1:0]    iREQ_VALID,
    output logic [P_REQ_N-1:0]    oREQ_BUSY,
    input  logic [P_REQ_N*32-1:0] iREQ_A,
    input  logic [P_REQ_N*32-1:0] iREQ_B,
    output logic                  oMUL_VALID,
    input  logic                  iMUL_BUSY,
    output logic [31:0]           oMUL_A,
    output logic [31:0]           oMUL_B,
    input  logic                  iMUL_VALID,
    output logic                  oMUL_BUSY,
    input  logic [31:0]           iMUL_DATA,
    output logic [P_REQ_N-1:0]    oRES_VALID,
    input  logic [P_REQ_N-1:0]    iRES_BUSY,
    output logic [31:0]           oRES_DATA,
    output logic                  oERR
);

    localparam int CW = $clog2(P_TAG_DEPTH + 1);

    logic [P_REQ_N-1:0] grant;
    logic [P_ID_W-1:0]  grant_id, idx;
    logic               can_grant, found;

    logic [P_ID_W-1:0]  rr_last_q, rr_last_d;
    logic               issue_valid_q, issue_valid_d;
    logic [31:0]        issue_a_q, issue_a_d, issue_b_q, issue_b_d;
    logic               res_valid_q, res_valid_d;
    logic [31:0]        res_data_q, res_data_d;
    logic [P_ID_W-1:0]  res_id_q, res_id_d;
    logic               err_q, err_d;

    logic               mul_busy, push, pop, fifo_empty;
    logic [CW-1:0]      tag_count;
    tag_entry_t         push_entry, head_entry;
    logic [P_REQ_N-1:0] res_vec;

    mul_float_tag_fifo #(.P_DEPTH(P_TAG_DEPTH)) u_tag_fifo (
        .iCLOCK     (iCLOCK),
        .inRESET    (inRESET),
        .iCLEAR     (iRESET_SYNC),
        .iPUSH      (push),
        .iPUSH_DATA (push_entry),
        .iPOP       (pop),
        .oHEAD      (head_entry),
        .oCOUNT     (tag_count),
        .oEMPTY     (fifo_empty)
    );

    // Count is registered, so a pop this cycle cannot free a slot this cycle.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        idx       = '0;
        found     = 1'b0;
        can_grant = (tag_count < CW'(P_TAG_DEPTH)) && !iMUL_BUSY;
        for (int k = 1; k <= P_REQ_N; k++) begin
            idx = P_ID_W'((int'(rr_last_q) + k) % P_REQ_N);
            if (!found && can_grant && iREQ_VALID[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = idx;
                found      = 1'b1;
            end
        end
    end

    assign mul_busy = res_valid_q && iRES_BUSY[res_id_q];

    always_comb begin
        rr_last_d     = rr_last_q;
        issue_valid_d = issue_valid_q;
        issue_a_d     = issue_a_q;
        issue_b_d     = issue_b_q;
        res_valid_d   = res_valid_q;
        res_data_d    = res_data_q;
        res_id_d      = res_id_q;
        err_d         = err_q;
        push          = |grant;
        pop           = 1'b0;
        push_entry.id = P_TAG_ID_W'(grant_id);

        if (!iMUL_BUSY) begin
            issue_valid_d = |grant;
            if (|grant) begin
                issue_a_d = iREQ_A[int'(grant_id)*32 +: 32];
                issue_b_d = iREQ_B[int'(grant_id)*32 +: 32];
            end
        end
        if (|grant) rr_last_d = grant_id;

        if (!mul_busy) begin
            res_valid_d = iMUL_VALID && !fifo_empty;
            res_data_d  = iMUL_DATA;
            res_id_d    = P_ID_W'(head_entry.id);
            pop         = iMUL_VALID && !fifo_empty;
            // A result with no owner is a protocol violation; drop it.
            if (iMUL_VALID && fifo_empty) err_d = 1'b1;
        end

        if (iRESET_SYNC) begin
            rr_last_d     = P_ID_W'(P_REQ_N - 1);
            issue_valid_d = 1'b0;
            issue_a_d     = P_ZERO;
            issue_b_d     = P_ZERO;
            res_valid_d   = 1'b0;
            res_data_d    = P_ZERO;
            res_id_d      = '0;
            err_d         = 1'b0;
            push          = 1'b0;
            pop           = 1'b0;
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            rr_last_q     <= P_ID_W'(P_REQ_N - 1);
            issue_valid_q <= 1'b0;
            issue_a_q     <= P_ZERO;
            issue_b_q     <= P_ZERO;
            res_valid_q   <= 1'b0;
            res_data_q    <= P_ZERO;
            res_id_q      <= '0;
            err_q         <= 1'b0;
        end else begin
            rr_last_q     <= rr_last_d;
            issue_valid_q <= issue_valid_d;
            issue_a_q     <= issue_a_d;
            issue_b_q     <= issue_b_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
            res_id_q      <= res_id_d;
            err_q         <= err_d;
        end
    end

    always_comb begin
        res_vec = '0;
        for (int i = 0; i < P_REQ_N; i++) begin
            res_vec[i] = res_valid_q && (res_id_q == P_ID_W'(i));
        end
    end

    assign oREQ_BUSY  = ~grant;
    assign oMUL_VALID = issue_valid_q;
    assign oMUL_A     = issue_a_q;
    assign oMUL_B     = issue_b_q;
    assign oMUL_BUSY  = mul_busy;
    assign oRES_VALID = res_vec;
    assign oRES_DATA  = res_data_q;
    assign oERR       = err_q;

endmodule

// File: tb/tb_mul_float_arbiter.sv
// Directed bench for mul_float_arbiter with an elastic 3-cycle multiplier model.
module tb_mul_float_arbiter;

    localparam int N = 4;
    localparam int L = 3;

    logic           iCLOCK      = 1'b0;
    logic           inRESET     = 1'b0;
    logic           iRESET_SYNC = 1'b0;
    logic [N-1:0]   iREQ_VALID  = '0;
    logic [N-1:0]   oREQ_BUSY;
    logic [N*32-1:0] iREQ_A     = '0;
    logic [N*32-1:0] iREQ_B     = '0;
    logic           oMUL_VALID;
    logic           iMUL_BUSY   = 1'b0;
    logic [31:0]    oMUL_A, oMUL_B;
    logic           iMUL_VALID;
    logic           oMUL_BUSY;
    logic [31:0]    iMUL_DATA;
    logic [N-1:0]   oRES_VALID;
    logic [N-1:0]   iRES_BUSY   = '0;
    logic [31:0]    oRES_DATA;
    logic           oERR;

    int checks = 0;
    int errors = 0;

    mul_float_arbiter #(.P_REQ_N(N), .P_TAG_DEPTH(8)) dut (
        .iCLOCK      (iCLOCK),
        .inRESET     (inRESET),
        .iRESET_SYNC (iRESET_SYNC),
        .iREQ_VALID  (iREQ_VALID),
        .oREQ_BUSY   (oREQ_BUSY),
        .iREQ_A      (iREQ_A),
        .iREQ_B      (iREQ_B),
        .oMUL_VALID  (oMUL_VALID),
        .iMUL_BUSY   (iMUL_BUSY),
        .oMUL_A      (oMUL_A),
        .oMUL_B      (oMUL_B),
        .iMUL_VALID  (iMUL_VALID),
        .oMUL_BUSY   (oMUL_BUSY),
        .iMUL_DATA   (iMUL_DATA),
        .oRES_VALID  (oRES_VALID),
        .iRES_BUSY   (iRES_BUSY),
        .oRES_DATA   (oRES_DATA),
        .oERR        (oERR)
    );

    always #5 iCLOCK = ~iCLOCK;

    // Multiplier model: elastic queue, result ready L cycles after acceptance.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [47:0] m;
        int          e;
        s = a[31] ^ b[31];
        if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0)) return 32'h7FC0_0000;
        if ((a[30:23] == 8'hFF && b[30:0] == 0) || (b[30:23] == 8'hFF && a[30:0] == 0)) return 32'h7FC0_0000;
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {s, 8'hFF, 23'h0};
        if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {s, 31'h0};
        m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (m[47]) return {s, 8'(e + 1), m[46:24]};
        return {s, 8'(e), m[45:23]};
    endfunction

    int          edges = 0;
    logic [31:0] mq_data  [32];
    int          mq_ready [32];
    logic [4:0]  mq_wr = '0, mq_rd = '0;
    logic        mul_out_hold = 1'b0;
    logic        spur = 1'b0;
    logic        mdl_valid;

    assign mdl_valid  = (mq_wr != mq_rd) && (edges >= mq_ready[mq_rd]) && !mul_out_hold;
    assign iMUL_VALID = mdl_valid | spur;
    assign iMUL_DATA  = mdl_valid ? mq_data[mq_rd] : 32'h0;

    always @(posedge iCLOCK) begin
        edges <= edges + 1;
        if (iRESET_SYNC) begin
            mq_wr <= '0;
            mq_rd <= '0;
        end else begin
            if (oMUL_VALID && !iMUL_BUSY) begin
                mq_data[mq_wr]  <= fmul(oMUL_A, oMUL_B);
                mq_ready[mq_wr] <= edges + L;
                mq_wr           <= mq_wr + 1'b1;
            end
            if (mdl_valid && !oMUL_BUSY) mq_rd <= mq_rd + 1'b1;
        end
    end

    // Grant and result logs, sampled at the active edge (pre-update values).
    int          g_log    [256];
    int          g_n = 0;
    int          log_id   [256];
    logic [31:0] log_data [256];
    int          log_n = 0;

    always @(posedge iCLOCK) begin
        for (int i = 0; i < N; i++) begin
            if (iREQ_VALID[i] && !oREQ_BUSY[i]) begin
                g_log[g_n] <= i;
                g_n        <= g_n + 1;
            end
            if (oRES_VALID[i] && !iRES_BUSY[i]) begin
                log_id[log_n]   <= i;
                log_data[log_n] <= oRES_DATA;
                log_n           <= log_n + 1;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input int i, input logic [31:0] a, input logic [31:0] b);
        bit acc;
        acc = 1'b0;
        @(negedge iCLOCK);
        iREQ_VALID[i]       = 1'b1;
        iREQ_A[32*i +: 32]  = a;
        iREQ_B[32*i +: 32]  = b;
        for (int k = 0; k < 50 && !acc; k++) begin
            #1;
            acc = !oREQ_BUSY[i];
            @(posedge iCLOCK);
        end
        @(negedge iCLOCK);
        iREQ_VALID[i] = 1'b0;
        check("send_accept", 32'(acc), 32'd1);
    endtask

    task automatic wait_log(input int target);
        for (int k = 0; k < 100 && log_n < target; k++) @(negedge iCLOCK);
    endtask

    logic [31:0] fair_b   [4] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
    logic [31:0] fair_exp [4] = '{32'h4000_0000, 32'h4080_0000, 32'h40C0_0000, 32'h4100_0000};

    initial begin
        int t0, base, gbase, bh, lr;

        repeat (3) @(negedge iCLOCK);
        check("rst_mul_valid", 32'(oMUL_VALID), 0);
        check("rst_mul_a",     oMUL_A, 0);
        check("rst_mul_b",     oMUL_B, 0);
        check("rst_res_valid", 32'(oRES_VALID), 0);
        check("rst_res_data",  oRES_DATA, 0);
        check("rst_err",       32'(oERR), 0);
        check("rst_req_busy",  32'(oREQ_BUSY), 32'hF);
        inRESET = 1'b1;

        // Single op from requester 2: 1.5 * 2.0 = 3.0
        @(negedge iCLOCK);
        iREQ_VALID[2]  = 1'b1;
        iREQ_A[95:64]  = 32'h3FC0_0000;
        iREQ_B[95:64]  = 32'h4000_0000;
        t0 = edges;
        #1 check("single_grant", 32'(oREQ_BUSY), 32'b1011);
        @(negedge iCLOCK);
        iREQ_VALID = '0;
        check("single_issue_valid", 32'(oMUL_VALID), 1);
        check("single_issue_a", oMUL_A, 32'h3FC0_0000);
        for (int k = 0; k < 20 && oRES_VALID == 0; k++) @(negedge iCLOCK);
        check("single_latency", 32'(edges - t0), 32'(L + 2));
        check("single_onehot", 32'(oRES_VALID), 32'b0100);
        check("single_data", oRES_DATA, 32'h4040_0000);

        @(negedge iCLOCK) iRESET_SYNC = 1'b1;
        @(negedge iCLOCK) iRESET_SYNC = 1'b0;

        // Fairness: all four requesters hold valid for 8 grants.
        gbase = g_n;
        base  = log_n;
        for (int i = 0; i < N; i++) begin
            iREQ_A[32*i +: 32] = 32'h4000_0000;
            iREQ_B[32*i +: 32] = fair_b[i];
        end
        iREQ_VALID = 4'hF;
        for (int k = 0; k < 40 && g_n < gbase + 8; k++) @(negedge iCLOCK);
        iREQ_VALID = '0;
        check("fair_grant_count", 32'(g_n - gbase), 8);
        for (int k = 0; k < 8; k++) check("fair_grant_order", 32'(g_log[gbase+k]), 32'(k % 4));
        wait_log(base + 8);
        for (int k = 0; k < 8; k++) begin
            check("fair_res_id",   32'(log_id[base+k]), 32'(k % 4));
            check("fair_res_data", log_data[base+k], fair_exp[k % 4]);
        end

        // Response backpressure on requester 1 for 10 cycles.
        base = log_n;
        iRES_BUSY[1] = 1'b1;
        send(1, 32'h4040_0000, 32'h4040_0000);
        send(0, 32'h4000_0000, 32'h4000_0000);
        send(2, 32'h3FC0_0000, 32'h3FC0_0000);
        for (int k = 0; k < 20 && oRES_VALID != 4'b0010; k++) @(negedge iCLOCK);
        bh = 0;
        for (int k = 0; k < 10; k++) begin
            bh += int'(oMUL_BUSY);
            @(negedge iCLOCK);
        end
        check("bp_mul_busy_cycles", 32'(bh), 10);
        check("bp_nothing_delivered", 32'(log_n - base), 0);
        iRES_BUSY[1] = 1'b0;
        wait_log(base + 3);
        check("bp_id0",   32'(log_id[base]),   1);
        check("bp_data0", log_data[base],      32'h4110_0000);
        check("bp_id1",   32'(log_id[base+1]), 0);
        check("bp_data1", log_data[base+1],    32'h4080_0000);
        check("bp_id2",   32'(log_id[base+2]), 2);
        check("bp_data2", log_data[base+2],    32'h4010_0000);

        // Exception: inf * 0 from requester 3.
        base = log_n;
        send(3, 32'h7F80_0000, 32'h0000_0000);
        wait_log(base + 1);
        check("exc_id",   32'(log_id[base]), 3);
        check("exc_data", log_data[base],    32'h7FC0_0000);

        // Multiplier input stall blocks all grants.
        @(negedge iCLOCK);
        iMUL_BUSY     = 1'b1;
        iREQ_VALID[0] = 1'b1;
        #1 check("mulbusy_no_grant", 32'(oREQ_BUSY), 32'hF);
        @(negedge iCLOCK);
        iREQ_VALID = '0;
        iMUL_BUSY  = 1'b0;

        // FIFO full: multiplier output held, results blocked.
        gbase = g_n;
        base  = log_n;
        mul_out_hold = 1'b1;
        iRES_BUSY    = 4'hF;
        for (int i = 0; i < N; i++) begin
            iREQ_A[32*i +: 32] = 32'h3F80_0000;
            iREQ_B[32*i +: 32] = 32'h3F80_0000;
        end
        iREQ_VALID = 4'hF;
        repeat (12) @(negedge iCLOCK);
        check("full_grants", 32'(g_n - gbase), 8);
        check("full_all_busy", 32'(oREQ_BUSY), 32'hF);
        mul_out_hold = 1'b0;
        #1 check("full_pop_cycle_busy", 32'(oREQ_BUSY), 32'hF);
        @(negedge iCLOCK);
        #1 check("full_regrant_after_pop", 32'(oREQ_BUSY == 4'hF), 0);
        @(negedge iCLOCK);
        iREQ_VALID = '0;
        check("full_total_grants", 32'(g_n - gbase), 9);
        iRES_BUSY = '0;
        wait_log(base + 9);
        check("full_drained", 32'(log_n - base), 9);
        check("full_last_data", log_data[base+8], 32'h3F80_0000);

        // Spurious multiplier result with an empty FIFO.
        @(negedge iCLOCK) spur = 1'b1;
        @(negedge iCLOCK) spur = 1'b0;
        #1;
        check("spur_err", 32'(oERR), 1);
        check("spur_dropped", 32'(oRES_VALID), 0);
        @(negedge iCLOCK);
        check("spur_err_sticky", 32'(oERR), 1);

        // Synchronous reset mid-stream.
        for (int i = 0; i < N; i++) begin
            iREQ_A[32*i +: 32] = 32'h4000_0000;
            iREQ_B[32*i +: 32] = 32'h4000_0000;
        end
        iREQ_VALID = 4'hF;
        repeat (5) @(negedge iCLOCK);
        check("midrst_inflight", 32'(oRES_VALID != 0), 1);
        iREQ_VALID  = '0;
        iRESET_SYNC = 1'b1;
        @(negedge iCLOCK);
        lr = log_n;
        check("midrst_mul_valid", 32'(oMUL_VALID), 0);
        check("midrst_mul_a",     oMUL_A, 0);
        check("midrst_mul_b",     oMUL_B, 0);
        check("midrst_res_valid", 32'(oRES_VALID), 0);
        check("midrst_res_data",  oRES_DATA, 0);
        check("midrst_err",       32'(oERR), 0);
        iRESET_SYNC = 1'b0;
        repeat (8) @(negedge iCLOCK);
        check("midrst_no_results", 32'(log_n - lr), 0);
        check("midrst_res_idle",   32'(oRES_VALID), 0);
        check("midrst_req_busy",   32'(oREQ_BUSY), 32'hF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_float_arbiter.md
# mul_float_arbiter

Shares one pipelined single-precision float multiplier (whose last stage is the exception/pack stage) among P_REQ_N requesters. Round-robin arbitration, a registered issue stage, and an in-order tag FIFO that records which requester owns each in-flight operation. A registered response stage routes each result back to its owner. Sits between the requester clients and the multiplier pipeline input and output, using the team's valid/busy handshake on every side.

## Interface
- P_REQ_N, 4, number of requesters (2..8)
- P_TAG_DEPTH, 8, tag FIFO entries; must be ≥ multiplier pipeline depth + 2
- P_ID_W, $clog2(P_REQ_N), requester-id width
- iCLOCK  in  1  clock
- inRESET  in  1  reset, asynchronous, active-low
- iRESET_SYNC  in  1  synchronous clear, same effect as reset
- iREQ_VALID  in  P_REQ_N  per-requester request valid
- oREQ_BUSY  out  P_REQ_N  per-requester stall; request held while set
- iREQ_A  in  P_REQ_N*32  operand A, requester i at [32i+31:32i]
- iREQ_B  in  P_REQ_N*32  operand B, same packing
- oMUL_VALID  out  1  issue valid to multiplier
- iMUL_BUSY  in  1  multiplier input stall
- oMUL_A, oMUL_B  out  32 each  operands to multiplier
- iMUL_VALID  in  1  multiplier result valid
- oMUL_BUSY  out  1  stall to multiplier output
- iMUL_DATA  in  32  multiplier result
- oRES_VALID  out  P_REQ_N  one-hot result valid
- iRES_BUSY  in  P_REQ_N  per-requester result stall
- oRES_DATA  out  32  result, shared by all requesters
- oERR  out  1  sticky protocol error

## Operation
- Transfer on any interface = valid && !busy in the same cycle.
- Arbitration:
  - eligible = iREQ_VALID && (tag_count < P_TAG_DEPTH) && !iMUL_BUSY.
  - Round-robin search starts at rr_last+1, modulo P_REQ_N; grant is one-hot.
- oREQ_BUSY[i] = !grant[i]. Non-granted requesters see busy.
- Issue register:
  - Loads only when !iMUL_BUSY: b_issue_valid<=|grant, plus operands of the granted requester.
  - Holds its contents while iMUL_BUSY.
  - Drives oMUL_VALID/oMUL_A/oMUL_B.
- On grant: push the granted id into the tag FIFO; rr_last<=granted id. rr_last is unchanged when there is no grant.
- Response register:
  - Loads when !oMUL_BUSY: b_res_valid<=iMUL_VALID, b_res_data<=iMUL_DATA, b_res_id<=FIFO head.
  - A valid load pops the FIFO.
- oMUL_BUSY = b_res_valid && iRES_BUSY[b_res_id].
- oRES_VALID[i] = b_res_valid && (b_res_id==i). oRES_DATA = b_res_data.
- Push and pop in the same cycle: tag_count unchanged; both pointers advance, wrapping modulo P_TAG_DEPTH.
- iMUL_VALID with the FIFO empty and the response register loading:
  - oERR<=1 (sticky until reset).
  - The result is dropped; b_res_valid<=0.
- Full FIFO (count==P_TAG_DEPTH): no grant, all oREQ_BUSY=1. A pop in the same cycle does not enable a grant; count is registered.

## Timing
- Reset (inRESET low or iRESET_SYNC high):
  - oMUL_VALID=0, oMUL_A=oMUL_B=0, oRES_VALID=0, oRES_DATA=0, oERR=0.
  - FIFO empty; rr_last=P_REQ_N-1, so requester 0 is served first.
- Reset mid-operation discards in-flight tags. The multiplier is cleared by the same iRESET_SYNC.
- Request accepted at edge k → oMUL_VALID high after edge k.
- Result accepted at edge m → oRES_VALID high after edge m.
- Added latency: 2 cycles (one issue stage, one response stage) on top of the multiplier latency.
- Throughput: 1 op/cycle when there is no backpressure and the FIFO is not full.
- oREQ_BUSY and oMUL_BUSY are combinational from registered state and the input busy lines.

## Structure
- Package mul_float_pkg:
  - P_ZERO/P_INF/P_NAN constants.
  - a function for the P_ID_W calculation.
  - typedef for the tag-FIFO entry.
- Sub-module mul_float_tag_fifo: synchronous FIFO, P_TAG_DEPTH×P_ID_W, push/pop/count/head, full/empty.
- Arbiter, issue and response registers live in the top module.

## Test plan
- Single op:
  - Stimulus: requester 2 sends A=0x3FC00000, B=0x40000000.
  - Required: oRES_VALID=4'b0100, oRES_DATA=0x40400000, latency = multiplier latency + 2.
- Fairness:
  - Stimulus: all 4 requesters hold valid continuously.
  - Required: grants 0,1,2,3,0,… and each requester gets its own product back.
- Response backpressure:
  - Stimulus: requester 1 holds iRES_BUSY for 10 cycles.
  - Required: oMUL_BUSY stays high and results are not lost or reordered.
- FIFO full:
  - Stimulus: iRES_BUSY all high, 12 requests.
  - Required: exactly P_TAG_DEPTH=8 grants, then all oREQ_BUSY=1 until a pop.
- Exceptions:
  - Stimulus: 0x7F800000×0x00000000 from requester 3.
  - Required: oRES_DATA=0x7FC00000 routed to requester 3.
- Errors and reset:
  - Stimulus: spurious iMUL_VALID with the FIFO empty.
    - Required: oERR=1.
  - Stimulus: iRESET_SYNC mid-stream.
    - Required: all outputs return to reset values and oERR=0.
